// File: rtl/multiword_add_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multiword_add_sequencer_pkg                                          |
// | Shared word width, FSM state encoding and the even-parity helper.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package multiword_add_sequencer_pkg;

  localparam int WORD_W    = 16;
  localparam int MAX_WORDS = 8;
  localparam int PAR_W     = MAX_WORDS * WORD_W;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_FIN  = 2'd2;

  // Zero-extended callers are safe: extra zeros leave parity unchanged.
  function automatic logic even_parity(input logic [PAR_W-1:0] v);
    return ~(^v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/multiword_add_sequencer_adder16_slice.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder16_slice                                                        |
// | Combinational 16-bit add slice with carry-out and signed overflow.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module adder16_slice
  import multiword_add_sequencer_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout,
  output logic              ovf
);

  logic [WORD_W:0] w_full;

  assign w_full = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, cin};
  assign sum    = w_full[WORD_W-1:0];
  assign cout   = w_full[WORD_W];
  // Carry into the MSB is recovered from the MSB sum bit.
  assign ovf    = (a[WORD_W-1] ^ b[WORD_W-1] ^ sum[WORD_W-1]) ^ cout;

endmodule
`default_nettype wire

// File: rtl/multiword_add_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multiword_add_sequencer                                              |
// | Runs one 16-bit slice over WORDS cycles for wide add/sub with flags. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module multiword_add_sequencer
  import multiword_add_sequencer_pkg::*;
#(
  parameter int WORDS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  Cin,
  input  logic [WORDS*16-1:0]   A,
  input  logic [WORDS*16-1:0]   B,
  output logic                  ready,
  output logic                  done,
  output logic [WORDS*16-1:0]   Out,
  output logic                  Zero,
  output logic                  Cflag,
  output logic                  Sign,
  output logic                  Parity,
  output logic                  Overflow
);

  localparam int W     = WORDS * WORD_W;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] C_LAST = IDX_W'(WORDS - 1);

  state_t             r_state;
  state_t             w_next;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_out;
  logic [IDX_W-1:0]   r_idx;
  logic               r_sub;
  logic               r_carry;
  logic               r_top_ovf;
  logic               r_done;
  logic               r_zero;
  logic               r_cflag;
  logic               r_sign;
  logic               r_parity;
  logic               r_ovf;
  logic               w_ready;
  logic [WORD_W-1:0]  w_a;
  logic [WORD_W-1:0]  w_b;
  logic [WORD_W-1:0]  w_sum;
  logic               w_cout;
  logic               w_ovf;

  assign w_a = r_a[r_idx*WORD_W +: WORD_W];
  assign w_b = r_sub ? ~r_b[r_idx*WORD_W +: WORD_W] : r_b[r_idx*WORD_W +: WORD_W];

  adder16_slice u_slice (
    .a    (w_a),
    .b    (w_b),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout),
    .ovf  (w_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_RUN;
      ST_RUN:  if (r_idx == C_LAST) w_next = ST_FIN;
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ready = (r_state == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_out     <= '0;
      r_idx     <= '0;
      r_sub     <= 1'b0;
      r_carry   <= 1'b0;
      r_top_ovf <= 1'b0;
      r_done    <= 1'b0;
      r_zero    <= 1'b0;
      r_cflag   <= 1'b0;
      r_sign    <= 1'b0;
      r_parity  <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_sub   <= sub;
            r_carry <= sub ? 1'b1 : Cin;
            r_idx   <= '0;
          end
        end
        ST_RUN: begin
          r_out[r_idx*WORD_W +: WORD_W] <= w_sum;
          r_carry <= w_cout;
          if (r_idx == C_LAST) r_top_ovf <= w_ovf;
          else                 r_idx     <= r_idx + 1'b1;
        end
        ST_FIN: begin
          // Out is complete here; flags are evaluated over the full width.
          r_zero   <= ~(|r_out);
          r_sign   <= r_out[W-1];
          r_parity <= even_parity(PAR_W'(r_out));
          r_cflag  <= r_carry;
          r_ovf    <= r_top_ovf;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ready    = w_ready;
  assign done     = r_done;
  assign Out      = r_out;
  assign Zero     = r_zero;
  assign Cflag    = r_cflag;
  assign Sign     = r_sign;
  assign Parity   = r_parity;
  assign Overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_multiword_add_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_multiword_add_sequencer                                           |
// | Directed vectors checked against an arithmetic model of wide add.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_multiword_add_sequencer;

  localparam int WORDS = 2;
  localparam int W     = WORDS * 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic         Cin;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         ready;
  logic         done;
  logic [W-1:0] Out;
  logic         Zero;
  logic         Cflag;
  logic         Sign;
  logic         Parity;
  logic         Overflow;

  // flags packed as {Zero, Cflag, Sign, Parity, Overflow}
  typedef struct packed {
    logic [W-1:0] out;
    logic [4:0]   f;
  } res_t;

  res_t expq[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   done_cnt   = 0;

  multiword_add_sequencer #(.WORDS(WORDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .Cin      (Cin),
    .A        (A),
    .B        (B),
    .ready    (ready),
    .done     (done),
    .Out      (Out),
    .Zero     (Zero),
    .Cflag    (Cflag),
    .Sign     (Sign),
    .Parity   (Parity),
    .Overflow (Overflow)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic s, input logic ci,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]   full;
    logic [W-1:0] bb;
    res_t         r;
    bb    = s ? ~b : b;
    full  = {1'b0, a} + {1'b0, bb} + (W+1)'(s ? 1'b1 : ci);
    r.out = full[W-1:0];
    r.f   = {r.out == '0, full[W], r.out[W-1], ~(^r.out),
             (a[W-1] == bb[W-1]) && (r.out[W-1] != a[W-1])};
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    res_t e;
    #1;
    if (done === 1'b1) begin
      done_cnt++;
      if (expq.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        e = expq.pop_front();
        chk("model_out", 64'(Out), 64'(e.out));
        chk("model_flags", 64'({Zero, Cflag, Sign, Parity, Overflow}), 64'(e.f));
      end
    end
  end

  task automatic run_op(input logic s, input logic ci, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic lit, input res_t exp);
    int lat;
    lat = 0;
    @(negedge clk);
    start = 1'b1; sub = s; Cin = ci; A = a; B = b;
    expq.push_back(model(s, ci, a, b));
    if (lit) chk("model_pin", 64'(model(s, ci, a, b)), 64'(exp));
    @(negedge clk);
    start = 1'b0;
    chk("ready_busy", 64'(ready), 64'd0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1) break;
    end
    chk("latency", 64'(lat), 64'(WORDS + 1));
    if (lit) chk("lit_result", 64'({Out, Zero, Cflag, Sign, Parity, Overflow}), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc0;
    rst = 1'b1; start = 1'b0; sub = 1'b0; Cin = 1'b0; A = '0; B = '0;
    #1;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_out", 64'(Out), 64'd0);
    chk("rst_flags", 64'({Zero, Cflag, Sign, Parity, Overflow}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(1'b0, 1'b0, 32'h0000FFFF, 32'h00000001, 1'b1, {32'h00010000, 5'b00000});
    run_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b1, {32'h00000000, 5'b11010});
    run_op(1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b1, {32'h80000000, 5'b00101});
    run_op(1'b0, 1'b1, 32'h00000000, 32'h00000000, 1'b1, {32'h00000001, 5'b00000});
    run_op(1'b1, 1'b0, 32'h00010000, 32'h00000001, 1'b1, {32'h0000FFFF, 5'b01010});
    run_op(1'b1, 1'b0, 32'h80000000, 32'h00000001, 1'b1, {32'h7FFFFFFF, 5'b01001});
    // Cin must be ignored on subtract.
    run_op(1'b1, 1'b1, 32'h12345678, 32'h12345678, 1'b1, {32'h00000000, 5'b11010});
    run_op(1'b1, 1'b0, 32'h00000000, 32'h00000001, 1'b1, {32'hFFFFFFFF, 5'b00110});
    run_op(1'b0, 1'b1, 32'hFFFF0000, 32'h0000FFFF, 1'b0, '0);
    run_op(1'b0, 1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b0, '0);
    run_op(1'b1, 1'b0, 32'h7FFF0000, 32'hFFFF0001, 1'b0, '0);

    // start held high while busy, with different operands
    dc0 = done_cnt;
    @(negedge clk);
    start = 1'b1; sub = 1'b0; Cin = 1'b0; A = 32'h11112222; B = 32'h00000001;
    expq.push_back(model(1'b0, 1'b0, 32'h11112222, 32'h00000001));
    @(negedge clk);
    sub = 1'b1; A = 32'hDEAD0000; B = 32'hBEEF0000;
    chk("ready_run", 64'(ready), 64'd0);
    @(negedge clk);
    chk("ready_fin", 64'(ready), 64'd0);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("done_pulses", 64'(done_cnt - dc0), 64'd1);
    chk("held_out", 64'(Out), 64'h11112223);

    // reset mid-run: Out holds 0x11112223 beforehand, so clearing is observable
    dc0 = done_cnt;
    @(negedge clk);
    start = 1'b1; sub = 1'b0; A = 32'h0F0F0F0F; B = 32'h01010101;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_ready", 64'(ready), 64'd1);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_out", 64'(Out), 64'd0);
    chk("arst_flags", 64'({Zero, Cflag, Sign, Parity, Overflow}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("arst_no_done", 64'(done_cnt - dc0), 64'd0);
    run_op(1'b0, 1'b0, 32'h0000FFFF, 32'h00000001, 1'b1, {32'h00010000, 5'b00000});

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(expq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
